// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Multi-cycle controller for the 3-bit calculator datapath. Accepts one
//   operation over a valid/ready handshake and runs it on a shared 6-bit
//   accumulator (multiplication is repeated addition). The two's-complement
//   result is converted to sign-magnitude and held until the display side
//   takes it.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/opcode presented
//   in_ready   out  high only while idle
//   a, b       in   3-bit two's-complement operands (-4..3)
//   op         in   00 ADD, 01 SUB, 10 MUL, 11 ABSDIFF
//   res_valid  out  result held valid
//   res_ready  in   downstream accepts result
//   res_sign   out  1 = negative result
//   res_mag    out  result magnitude (0..16)
//   busy       out  high in any state other than idle
module calc_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [1:0] op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_sign,
    output logic [4:0] res_mag,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t             state_q, state_d;
    logic        [2:0]  a_q, a_d;
    logic        [2:0]  b_q, b_d;
    logic        [1:0]  op_q, op_d;
    logic signed [5:0]  acc_q, acc_d;
    logic        [2:0]  cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic        [4:0]  mag_q, mag_d;
    logic signed [5:0]  v_c;

    function automatic logic signed [5:0] sext3(input logic [2:0] x);
        return {{3{x[2]}}, x};
    endfunction

    function automatic logic [2:0] abs3(input logic [2:0] x);
        return x[2] ? (~x + 3'd1) : x;
    endfunction

    // Results never exceed 16 in magnitude, so only the low five bits of the
    // negated value are needed; -16 (110000) maps to 10000 correctly.
    function automatic logic [4:0] abs6(input logic signed [5:0] x);
        return x[5] ? (~x[4:0] + 5'd1) : x[4:0];
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        // MUL accumulates |a|*b, so a negative multiplier negates at the end.
        v_c     = (op_q == OP_MUL && a_q[2]) ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    acc_d   = '0;
                    // a=0 still spends one EXEC cycle (adding nothing).
                    cnt_d   = (a == 3'd0) ? 3'd1 : abs3(a);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_MUL) begin
                    if (a_q != 3'd0) begin
                        acc_d = acc_q + sext3(b_q);
                    end
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_CONV;
                    end
                end else begin
                    if (op_q == OP_ADD) begin
                        acc_d = sext3(a_q) + sext3(b_q);
                    end else begin
                        acc_d = sext3(a_q) - sext3(b_q);
                    end
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (op_q == OP_SUB || op_q == OP_ADD || op_q == OP_MUL) begin
                    // Sign is suppressed for zero so -0 never appears.
                    sign_d = v_c[5] & (v_c != 6'sd0);
                    mag_d  = abs6(v_c);
                end else begin
                    sign_d = 1'b0;
                    mag_d  = abs6(acc_q);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
        end
    end

    // Captured operands are only read after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_sign  = sign_q;
    assign res_mag   = mag_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
    logic       res_valid;
    logic       res_ready;
    logic       res_sign;
    logic [4:0] res_mag;
    logic       busy;

    int total = 0;
    int bad   = 0;

    calc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sign  (res_sign),
        .res_mag   (res_mag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge. Presents one operation, waits for
    // res_valid and checks latency and result. Returns at a falling edge in DONE.
    task automatic run_op(input string tag, input int av, input int bv, input int opv,
                          input int exp_lat, input int exp_sign, input int exp_mag);
        int lat;
        chk({tag, "_in_ready"}, 8'(in_ready), 8'd1);
        in_valid = 1'b1;
        a        = 3'(av);
        b        = 3'(bv);
        op       = 2'(opv);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 3'b011;
        b        = 3'b101;
        op       = 2'b01;
        lat      = 0;
        while (!res_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 8'(lat), 8'(exp_lat));
        chk({tag, "_res_valid"}, 8'(res_valid), 8'd1);
        chk({tag, "_sign"}, 8'(res_sign), 8'(exp_sign));
        chk({tag, "_mag"}, 8'(res_mag), 8'(exp_mag));
        chk({tag, "_busy"}, 8'(busy), 8'd1);
        chk({tag, "_in_ready_busy"}, 8'(in_ready), 8'd0);
    endtask

    // res_ready already high: DONE lasts one cycle, then IDLE with result held.
    task automatic finish_hs(input string tag, input int exp_sign, input int exp_mag);
        @(negedge clk);
        chk({tag, "_hs_in_ready"}, 8'(in_ready), 8'd1);
        chk({tag, "_hs_res_valid"}, 8'(res_valid), 8'd0);
        chk({tag, "_hs_busy"}, 8'(busy), 8'd0);
        chk({tag, "_hs_sign"}, 8'(res_sign), 8'(exp_sign));
        chk({tag, "_hs_mag"}, 8'(res_mag), 8'(exp_mag));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 3'd0;
        b         = 3'd0;
        op        = 2'd0;
        res_ready = 1'b0;

        #12;
        chk("rst_res_valid", 8'(res_valid), 8'd0);
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_sign", 8'(res_sign), 8'd0);
        chk("rst_mag", 8'(res_mag), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with negative result, res_ready held high in advance
        res_ready = 1'b1;
        run_op("add_neg", -4, -3, 0, 2, 1, 7);
        finish_hs("add_neg", 1, 7);

        // Reset in the middle of a MUL
        res_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 3'(-4);
        b         = 3'd3;
        op        = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midmul_busy_before", 8'(busy), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmul_res_valid", 8'(res_valid), 8'd0);
        chk("midmul_busy", 8'(busy), 8'd0);
        chk("midmul_in_ready", 8'(in_ready), 8'd1);
        chk("midmul_sign", 8'(res_sign), 8'd0);
        chk("midmul_mag", 8'(res_mag), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midmul_post_res_valid", 8'(res_valid), 8'd0);
        chk("midmul_post_in_ready", 8'(in_ready), 8'd1);

        res_ready = 1'b1;
        run_op("sub_neg", -4, 3, 1, 2, 1, 7);
        finish_hs("sub_neg", 1, 7);
        run_op("absdiff", -4, 3, 3, 2, 0, 7);
        finish_hs("absdiff", 0, 7);
        run_op("absdiff_negacc", 1, 3, 3, 2, 0, 2);
        finish_hs("absdiff_negacc", 0, 2);
        run_op("sub_zero", 2, 2, 1, 2, 0, 0);
        finish_hs("sub_zero", 0, 0);
        run_op("add_pos", 3, 3, 0, 2, 0, 6);
        finish_hs("add_pos", 0, 6);
        run_op("mul_m4m4", -4, -4, 2, 5, 0, 16);
        finish_hs("mul_m4m4", 0, 16);
        run_op("mul_3m4", 3, -4, 2, 4, 1, 12);
        finish_hs("mul_3m4", 1, 12);
        run_op("mul_0m3", 0, -3, 2, 2, 0, 0);
        finish_hs("mul_0m3", 0, 0);
        run_op("mul_m1x3", -1, 3, 2, 2, 1, 3);
        finish_hs("mul_m1x3", 1, 3);
        run_op("mul_2x3", 2, 3, 2, 3, 0, 6);
        finish_hs("mul_2x3", 0, 6);

        // Backpressure: stall in DONE, in_valid pulses must be ignored
        res_ready = 1'b0;
        run_op("bp_mul", -3, 2, 2, 4, 1, 6);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 3'd3;
            b        = 3'd3;
            op       = 2'd0;
            @(negedge clk);
            chk("bp_res_valid", 8'(res_valid), 8'd1);
            chk("bp_sign", 8'(res_sign), 8'd1);
            chk("bp_mag", 8'(res_mag), 8'd6);
            chk("bp_in_ready", 8'(in_ready), 8'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        finish_hs("bp_release", 1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
